// File: rtl/fanin_pkg.sv
// Shared constants, source-index type and index helper for the child fan-in arbiter.
package fanin_pkg;

  localparam int unsigned N_CHILD_DEFAULT = 5;
  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned SRC_W_DEFAULT   = $clog2(N_CHILD_DEFAULT);
  localparam int unsigned CNT_W           = 16;

  typedef logic [SRC_W_DEFAULT-1:0] src_idx_t;

  // Successor of idx in a ring of n children.
  function automatic src_idx_t next_idx(input src_idx_t idx,
                                        input int unsigned n = N_CHILD_DEFAULT);
    int unsigned nxt;
    nxt = 32'(idx) + 32'd1;
    return (nxt >= n) ? '0 : src_idx_t'(nxt);
  endfunction

endpackage

// File: rtl/child_fanin_arbiter_if.sv
// Bundle of the per-child input streams and the single tagged output stream.
interface child_fanin_arbiter_if
  import fanin_pkg::*;
#(
  parameter int unsigned N_CHILD = N_CHILD_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned SRC_W   = $clog2(N_CHILD)
);

  logic [N_CHILD-1:0]        in_valid;
  logic [N_CHILD*DATA_W-1:0] in_data;
  logic [N_CHILD-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  logic                      out_ready;

  // Arbiter side: consumes child streams, produces the merged stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  // Environment side: children and downstream consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/child_fanin_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick
  import fanin_pkg::*;
#(
  parameter int unsigned N_CHILD = N_CHILD_DEFAULT,
  parameter int unsigned SRC_W   = $clog2(N_CHILD)
) (
  input  logic [N_CHILD-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               found,
  output logic [SRC_W-1:0]   idx
);

  int unsigned j;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N_CHILD - 1; k >= 0; k--) begin
      j = (32'(ptr) + 32'(k)) % N_CHILD;
      if (req[j]) begin
        found = 1'b1;
        idx   = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/child_fanin_arbiter.sv
// Five-way round-robin fan-in of child streams into one registered, source-tagged stream.
module child_fanin_arbiter
  import fanin_pkg::*;
#(
  parameter int unsigned N_CHILD = N_CHILD_DEFAULT,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned SRC_W   = $clog2(N_CHILD)
) (
  input  logic                    clk,
  input  logic                    rst,
  child_fanin_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]        xfer_count
);

  logic [SRC_W-1:0] ptr;
  logic             found_c;
  logic [SRC_W-1:0] win_c;
  logic             slot_free_c;
  logic             take_c;
  logic             drain_c;

  rr_pick #(
    .N_CHILD (N_CHILD),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (ptr),
    .found (found_c),
    .idx   (win_c)
  );

  // Slot frees when empty or being drained; reset blocks any grant.
  always_comb begin
    slot_free_c = !bus.out_valid || bus.out_ready;
    take_c      = found_c && slot_free_c && !rst;
    drain_c     = bus.out_valid && bus.out_ready;
  end

  // One-hot ready to the winner only.
  always_comb begin
    bus.in_ready = '0;
    if (take_c) begin
      bus.in_ready[win_c] = 1'b1;
    end
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      ptr           <= '0;
    end else if (take_c) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[32'(win_c)*DATA_W +: DATA_W];
      bus.out_src   <= win_c;
      ptr           <= SRC_W'(next_idx(src_idx_t'(win_c), N_CHILD));
    end else if (drain_c) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Saturating count of delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (drain_c && (xfer_count != {CNT_W{1'b1}})) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule
